l2_bufs_q: RTL

- Parametrised successor to the L2 set-read capture buffer: a DEPTH-entry FIFO of complete set snapshots (all ways' line/tag/hprot/state plus evict way and set index).
- Lets the L2 controller queue several set reads ahead of the decision logic instead of holding a single snapshot.
- Snoops L2 array writes and patches any queued snapshot of the same set, so buffered copies never go stale.
- Sits between the L2 tag/data/state arrays and the L2 FSM.

---
 rtl/l2_bufs_q_if.sv | 60 ++++++
 rtl/l2_bufs_q.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/l2_bufs_q_if.sv
// Bundle of the L2 set-read snapshot queue: array read push, write snoop, and
// head-of-queue snapshot toward the L2 FSM.
interface l2_bufs_q_if #(
    parameter int WAYS    = 8,
    parameter int WAY_W   = $clog2(WAYS),
    parameter int LINE_W  = 128,
    parameter int TAG_W   = 20,
    parameter int HPROT_W = 1,
    parameter int STATE_W = 3,
    parameter int SET_W   = 9,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = $clog2(DEPTH + 1)
);
    logic                       rd_mem_en;
    logic [SET_W-1:0]           rd_set;
    logic [WAYS*LINE_W-1:0]     rd_data_line;
    logic [WAYS*TAG_W-1:0]      rd_data_tag;
    logic [WAYS*HPROT_W-1:0]    rd_data_hprot;
    logic [WAYS*STATE_W-1:0]    rd_data_state;
    logic [WAY_W-1:0]           rd_data_evict_way;
    logic                       rd_mem_ready;

    logic                       wr_en;
    logic [SET_W-1:0]           wr_set;
    logic [WAY_W-1:0]           wr_way;
    logic [LINE_W-1:0]          wr_line;
    logic [TAG_W-1:0]           wr_tag;
    logic [HPROT_W-1:0]         wr_hprot;
    logic [STATE_W-1:0]         wr_state;

    logic                       buf_valid;
    logic                       buf_pop;
    logic [SET_W-1:0]           buf_set;
    logic [WAY_W-1:0]           evict_way_buf;
    logic [WAYS*LINE_W-1:0]     lines_buf;
    logic [WAYS*TAG_W-1:0]      tags_buf;
    logic [WAYS*HPROT_W-1:0]    hprots_buf;
    logic [WAYS*STATE_W-1:0]    states_buf;
    logic [CNT_W-1:0]           count;
    logic                       err_ovf;
    logic                       err_udf;

    modport master (
        output rd_mem_en, rd_set, rd_data_line, rd_data_tag, rd_data_hprot,
               rd_data_state, rd_data_evict_way,
        output wr_en, wr_set, wr_way, wr_line, wr_tag, wr_hprot, wr_state,
        output buf_pop,
        input  rd_mem_ready, buf_valid, buf_set, evict_way_buf, lines_buf,
               tags_buf, hprots_buf, states_buf, count, err_ovf, err_udf
    );

    modport slave (
        input  rd_mem_en, rd_set, rd_data_line, rd_data_tag, rd_data_hprot,
               rd_data_state, rd_data_evict_way,
        input  wr_en, wr_set, wr_way, wr_line, wr_tag, wr_hprot, wr_state,
        input  buf_pop,
        output rd_mem_ready, buf_valid, buf_set, evict_way_buf, lines_buf,
               tags_buf, hprots_buf, states_buf, count, err_ovf, err_udf
    );
endinterface

// File: rtl/l2_bufs_q.sv
// DEPTH-entry FIFO of complete L2 set snapshots; array writes are snooped so
// queued copies of the written set are patched in place and never go stale.
module l2_bufs_q #(
    parameter int WAYS    = 8,
    parameter int WAY_W   = $clog2(WAYS),
    parameter int LINE_W  = 128,
    parameter int TAG_W   = 20,
    parameter int HPROT_W = 1,
    parameter int STATE_W = 3,
    parameter int SET_W   = 9,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic        clk,
    input  logic        rst,
    l2_bufs_q_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WAYS*LINE_W-1:0]  r_line  [DEPTH];
    logic [WAYS*TAG_W-1:0]   r_tag   [DEPTH];
    logic [WAYS*HPROT_W-1:0] r_hprot [DEPTH];
    logic [WAYS*STATE_W-1:0] r_state [DEPTH];
    logic [WAY_W-1:0]        r_evict [DEPTH];
    logic [SET_W-1:0]        r_set   [DEPTH];
    logic [DEPTH-1:0]        r_valid;

    logic [WAYS*LINE_W-1:0]  w_line_nxt  [DEPTH];
    logic [WAYS*TAG_W-1:0]   w_tag_nxt   [DEPTH];
    logic [WAYS*HPROT_W-1:0] w_hprot_nxt [DEPTH];
    logic [WAYS*STATE_W-1:0] w_state_nxt [DEPTH];
    logic [WAY_W-1:0]        w_evict_nxt [DEPTH];
    logic [SET_W-1:0]        w_set_nxt   [DEPTH];
    logic [DEPTH-1:0]        w_valid_nxt;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_err_ovf;
    logic             r_err_udf;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_snoop_push;

    assign w_full       = (r_count == CNT_W'(DEPTH));
    assign w_empty      = (r_count == {CNT_W{1'b0}});
    assign w_push       = bus.rd_mem_en && !w_full;
    assign w_pop        = bus.buf_pop && !w_empty;
    assign w_snoop_push = bus.wr_en && (bus.wr_set == bus.rd_set);

    // Next contents of every entry: fresh load on push, otherwise in-place snoop patch.
    always_comb begin
        w_valid_nxt = r_valid;
        for (int e = 0; e < DEPTH; e++) begin
            w_line_nxt[e]  = r_line[e];
            w_tag_nxt[e]   = r_tag[e];
            w_hprot_nxt[e] = r_hprot[e];
            w_state_nxt[e] = r_state[e];
            w_evict_nxt[e] = r_evict[e];
            w_set_nxt[e]   = r_set[e];
            if (w_pop && (r_rd_ptr == PTR_W'(e))) begin
                w_valid_nxt[e] = 1'b0;
            end else begin
                w_valid_nxt[e] = w_valid_nxt[e];
            end
            if (w_push && (r_wr_ptr == PTR_W'(e))) begin
                w_valid_nxt[e] = 1'b1;
                w_line_nxt[e]  = bus.rd_data_line;
                w_tag_nxt[e]   = bus.rd_data_tag;
                w_hprot_nxt[e] = bus.rd_data_hprot;
                w_state_nxt[e] = bus.rd_data_state;
                w_evict_nxt[e] = bus.rd_data_evict_way;
                w_set_nxt[e]   = bus.rd_set;
                if (w_snoop_push) begin
                    w_line_nxt[e][int'(bus.wr_way)*LINE_W +: LINE_W]    = bus.wr_line;
                    w_tag_nxt[e][int'(bus.wr_way)*TAG_W +: TAG_W]       = bus.wr_tag;
                    w_hprot_nxt[e][int'(bus.wr_way)*HPROT_W +: HPROT_W] = bus.wr_hprot;
                    w_state_nxt[e][int'(bus.wr_way)*STATE_W +: STATE_W] = bus.wr_state;
                end else begin
                    w_line_nxt[e] = w_line_nxt[e];
                end
            end else if (r_valid[e] && bus.wr_en && (r_set[e] == bus.wr_set)) begin
                // evict way is a read-time decision and stays as captured
                w_line_nxt[e][int'(bus.wr_way)*LINE_W +: LINE_W]    = bus.wr_line;
                w_tag_nxt[e][int'(bus.wr_way)*TAG_W +: TAG_W]       = bus.wr_tag;
                w_hprot_nxt[e][int'(bus.wr_way)*HPROT_W +: HPROT_W] = bus.wr_hprot;
                w_state_nxt[e][int'(bus.wr_way)*STATE_W +: STATE_W] = bus.wr_state;
            end else begin
                w_line_nxt[e] = r_line[e];
            end
        end
    end

    // Snapshot storage; cleared on reset so head outputs read back as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= {DEPTH{1'b0}};
            for (int e = 0; e < DEPTH; e++) begin
                r_line[e]  <= {(WAYS*LINE_W){1'b0}};
                r_tag[e]   <= {(WAYS*TAG_W){1'b0}};
                r_hprot[e] <= {(WAYS*HPROT_W){1'b0}};
                r_state[e] <= {(WAYS*STATE_W){1'b0}};
                r_evict[e] <= {WAY_W{1'b0}};
                r_set[e]   <= {SET_W{1'b0}};
            end
        end else begin
            r_valid <= w_valid_nxt;
            for (int e = 0; e < DEPTH; e++) begin
                r_line[e]  <= w_line_nxt[e];
                r_tag[e]   <= w_tag_nxt[e];
                r_hprot[e] <= w_hprot_nxt[e];
                r_state[e] <= w_state_nxt[e];
                r_evict[e] <= w_evict_nxt[e];
                r_set[e]   <= w_set_nxt[e];
            end
        end
    end

    // Pointers, occupancy and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= {PTR_W{1'b0}};
            r_rd_ptr  <= {PTR_W{1'b0}};
            r_count   <= {CNT_W{1'b0}};
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : r_wr_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : r_rd_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{(CNT_W-1){1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
            r_err_ovf <= r_err_ovf | (bus.rd_mem_en & w_full);
            r_err_udf <= r_err_udf | (bus.buf_pop & w_empty);
        end
    end

    assign bus.rd_mem_ready  = !w_full;
    assign bus.buf_valid     = !w_empty;
    assign bus.buf_set       = r_set[r_rd_ptr];
    assign bus.evict_way_buf = r_evict[r_rd_ptr];
    assign bus.lines_buf     = r_line[r_rd_ptr];
    assign bus.tags_buf      = r_tag[r_rd_ptr];
    assign bus.hprots_buf    = r_hprot[r_rd_ptr];
    assign bus.states_buf    = r_state[r_rd_ptr];
    assign bus.count         = r_count;
    assign bus.err_ovf       = r_err_ovf;
    assign bus.err_udf       = r_err_udf;
endmodule
